ysyx_22040237_core_ctrl: RTL and testbench

Multi-cycle sequencer that turns the combinational decode/execute datapath into a bus-driven core. It owns the PC, fetches one instruction at a time over a valid/ready instruction port, and holds the fetched instruction stable for the decoder. It then sequences the load/store access and issues a single register-file write strobe per instruction. It halts on `ebreak` and traps on invalid instructions, bus timeouts and misaligned targets.

---
 rtl/ysyx_22040237_pkg.sv | 32 +++
 rtl/ysyx_22040237_bus_wdog.sv | 28 ++
 rtl/ysyx_22040237_core_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ysyx_22040237_core_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040237_pkg.sv
// rtl/ysyx_22040237_pkg.sv - shared state encoding, trap causes and reset constants for the core sequencer
package ysyx_22040237_pkg;

   localparam logic [2:0] ST_FETCH_REQ  = 3'd0;
   localparam logic [2:0] ST_FETCH_WAIT = 3'd1;
   localparam logic [2:0] ST_EXEC       = 3'd2;
   localparam logic [2:0] ST_MEM_REQ    = 3'd3;
   localparam logic [2:0] ST_MEM_WAIT   = 3'd4;
   localparam logic [2:0] ST_WB         = 3'd5;
   localparam logic [2:0] ST_HALT       = 3'd6;
   localparam logic [2:0] ST_TRAP       = 3'd7;

   typedef enum logic [2:0] {
      FETCH_REQ  = ST_FETCH_REQ,
      FETCH_WAIT = ST_FETCH_WAIT,
      EXEC       = ST_EXEC,
      MEM_REQ    = ST_MEM_REQ,
      MEM_WAIT   = ST_MEM_WAIT,
      WB         = ST_WB,
      HALT       = ST_HALT,
      TRAP       = ST_TRAP
   } state_t;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_INVALID  = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

   localparam logic [63:0] DEFAULT_RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22040237_bus_wdog.sv
// rtl/ysyx_22040237_bus_wdog.sv - 16-bit bus wait-state counter flagging when the wait limit is reached
module ysyx_22040237_bus_wdog #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [15:0] LIMIT = 16'(BUS_TIMEOUT);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/ysyx_22040237_core_ctrl.sv
// rtl/ysyx_22040237_core_ctrl.sv - multi-cycle fetch/exec/mem/writeback sequencer owning PC, retire and cycle counters
module ysyx_22040237_core_ctrl
   import ysyx_22040237_pkg::*;
#(
   parameter logic [63:0] RST_PC      = DEFAULT_RST_PC,
   parameter int          BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ifu_req_valid_o,
   input  logic        ifu_req_ready_i,
   input  logic        ifu_rsp_valid_i,
   input  logic [31:0] ifu_rsp_inst_i,
   output logic [63:0] pc_o,
   output logic [31:0] inst_o,
   input  logic        invalid_inst_i,
   input  logic        ebreak_i,
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic        rd_wr_en_i,
   input  logic [63:0] next_pc_i,
   output logic        lsu_req_valid_o,
   input  logic        lsu_req_ready_i,
   input  logic        lsu_rsp_valid_i,
   output logic        rf_wr_en_o,
   output logic        wb_sel_mem_o,
   output logic        halt_o,
   output logic        trap_o,
   output logic [1:0]  trap_cause_o,
   output logic [63:0] instret_o,
   output logic [63:0] cycle_o
);

   state_t      state;
   logic [63:0] next_pc_q;
   logic        rd_wr_q;
   logic        is_load_q;
   logic        in_wait;
   logic        hs_done;
   logic        expired;
   logic        timeout;

   always_comb begin
      in_wait = 1'b1;
      hs_done = 1'b0;
      case (state)
         FETCH_REQ:  hs_done = ifu_req_ready_i;
         FETCH_WAIT: hs_done = ifu_rsp_valid_i;
         MEM_REQ:    hs_done = lsu_req_ready_i;
         MEM_WAIT:   hs_done = lsu_rsp_valid_i;
         default:    in_wait = 1'b0;
      endcase
   end

   // Every exit from a wait state is a completed handshake, so clearing on it
   // (and in all non-wait states) leaves the count at zero on entry.
   ysyx_22040237_bus_wdog #(
      .BUS_TIMEOUT(BUS_TIMEOUT)
   ) u_bus_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_wait || hs_done),
      .en      (in_wait),
      .expired (expired)
   );

   assign timeout = in_wait && !hs_done && expired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= FETCH_REQ;
         pc_o            <= RST_PC;
         inst_o          <= NOP_INST;
         next_pc_q       <= RST_PC;
         rd_wr_q         <= 1'b0;
         is_load_q       <= 1'b0;
         ifu_req_valid_o <= 1'b1;
         lsu_req_valid_o <= 1'b0;
         rf_wr_en_o      <= 1'b0;
         wb_sel_mem_o    <= 1'b0;
         halt_o          <= 1'b0;
         trap_o          <= 1'b0;
         trap_cause_o    <= CAUSE_NONE;
         instret_o       <= '0;
         cycle_o         <= '0;
      end else begin
         if (state != HALT && state != TRAP) begin
            cycle_o <= cycle_o + 64'd1;
         end
         if (timeout) begin
            state           <= TRAP;
            trap_o          <= 1'b1;
            trap_cause_o    <= CAUSE_TIMEOUT;
            ifu_req_valid_o <= 1'b0;
            lsu_req_valid_o <= 1'b0;
         end else begin
            case (state)
               FETCH_REQ: begin
                  if (ifu_req_ready_i) begin
                     ifu_req_valid_o <= 1'b0;
                     state           <= FETCH_WAIT;
                  end
               end
               FETCH_WAIT: begin
                  if (ifu_rsp_valid_i) begin
                     inst_o <= ifu_rsp_inst_i;
                     state  <= EXEC;
                  end
               end
               EXEC: begin
                  if (invalid_inst_i) begin
                     state        <= TRAP;
                     trap_o       <= 1'b1;
                     trap_cause_o <= CAUSE_INVALID;
                  end else if (ebreak_i) begin
                     state  <= HALT;
                     halt_o <= 1'b1;
                  end else if (next_pc_i[1:0] != 2'b00) begin
                     state        <= TRAP;
                     trap_o       <= 1'b1;
                     trap_cause_o <= CAUSE_MISALIGN;
                  end else begin
                     next_pc_q <= next_pc_i;
                     rd_wr_q   <= rd_wr_en_i;
                     is_load_q <= is_load_i;
                     if (is_load_i || is_store_i) begin
                        lsu_req_valid_o <= 1'b1;
                        state           <= MEM_REQ;
                     end else begin
                        rf_wr_en_o   <= rd_wr_en_i;
                        wb_sel_mem_o <= is_load_i;
                        state        <= WB;
                     end
                  end
               end
               MEM_REQ: begin
                  if (lsu_req_ready_i) begin
                     lsu_req_valid_o <= 1'b0;
                     state           <= MEM_WAIT;
                  end
               end
               MEM_WAIT: begin
                  if (lsu_rsp_valid_i) begin
                     rf_wr_en_o   <= rd_wr_q;
                     wb_sel_mem_o <= is_load_q;
                     state        <= WB;
                  end
               end
               WB: begin
                  rf_wr_en_o      <= 1'b0;
                  wb_sel_mem_o    <= 1'b0;
                  pc_o            <= next_pc_q;
                  instret_o       <= instret_o + 64'd1;
                  ifu_req_valid_o <= 1'b1;
                  state           <= FETCH_REQ;
               end
               HALT, TRAP: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040237_core_ctrl.sv
// tb/tb_ysyx_22040237_core_ctrl.sv - randomized self-checking bench for the core sequencer
module tb_ysyx_22040237_core_ctrl;

   localparam int          TMO    = 8;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ifu_req_valid_o;
   logic        ifu_req_ready_i = 1'b0;
   logic        ifu_rsp_valid_i = 1'b0;
   logic [31:0] ifu_rsp_inst_i = '0;
   logic [63:0] pc_o;
   logic [31:0] inst_o;
   logic        invalid_inst_i = 1'b0;
   logic        ebreak_i = 1'b0;
   logic        is_load_i = 1'b0;
   logic        is_store_i = 1'b0;
   logic        rd_wr_en_i = 1'b0;
   logic [63:0] next_pc_i = '0;
   logic        lsu_req_valid_o;
   logic        lsu_req_ready_i = 1'b0;
   logic        lsu_rsp_valid_i = 1'b0;
   logic        rf_wr_en_o;
   logic        wb_sel_mem_o;
   logic        halt_o;
   logic        trap_o;
   logic [1:0]  trap_cause_o;
   logic [63:0] instret_o;
   logic [63:0] cycle_o;

   always #5 clk = ~clk;

   ysyx_22040237_core_ctrl #(
      .RST_PC      (RST_PC),
      .BUS_TIMEOUT (TMO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ifu_req_valid_o (ifu_req_valid_o),
      .ifu_req_ready_i (ifu_req_ready_i),
      .ifu_rsp_valid_i (ifu_rsp_valid_i),
      .ifu_rsp_inst_i  (ifu_rsp_inst_i),
      .pc_o            (pc_o),
      .inst_o          (inst_o),
      .invalid_inst_i  (invalid_inst_i),
      .ebreak_i        (ebreak_i),
      .is_load_i       (is_load_i),
      .is_store_i      (is_store_i),
      .rd_wr_en_i      (rd_wr_en_i),
      .next_pc_i       (next_pc_i),
      .lsu_req_valid_o (lsu_req_valid_o),
      .lsu_req_ready_i (lsu_req_ready_i),
      .lsu_rsp_valid_i (lsu_rsp_valid_i),
      .rf_wr_en_o      (rf_wr_en_o),
      .wb_sel_mem_o    (wb_sel_mem_o),
      .halt_o          (halt_o),
      .trap_o          (trap_o),
      .trap_cause_o    (trap_cause_o),
      .instret_o       (instret_o),
      .cycle_o         (cycle_o)
   );

   int          checks = 0;
   int          fails = 0;
   int          wr_seen = 0;
   int          wr_exp = 0;
   logic [63:0] m_pc;
   logic [63:0] m_instret;
   logic [63:0] m_cycles;

   always @(negedge clk) begin
      if (rst_n && rf_wr_en_o === 1'b1) wr_seen++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic scramble();
      invalid_inst_i = 1'($urandom);
      ebreak_i       = 1'($urandom);
      is_load_i      = 1'($urandom);
      is_store_i     = 1'($urandom);
      rd_wr_en_i     = 1'($urandom);
      next_pc_i      = {$urandom, $urandom};
   endtask

   task automatic idle();
      ifu_req_ready_i = 1'b0;
      ifu_rsp_valid_i = 1'b0;
      lsu_req_ready_i = 1'b0;
      lsu_rsp_valid_i = 1'b0;
      invalid_inst_i  = 1'b0;
      ebreak_i        = 1'b0;
      is_load_i       = 1'b0;
      is_store_i      = 1'b0;
      rd_wr_en_i      = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pc"}, pc_o, RST_PC);
      check({tag, "_inst"}, 64'(inst_o), 64'h13);
      check({tag, "_instret"}, instret_o, 64'd0);
      check({tag, "_cycle"}, cycle_o, 64'd0);
      check({tag, "_flags"}, 64'({halt_o, trap_o, trap_cause_o, rf_wr_en_o, wb_sel_mem_o, lsu_req_valid_o}), 64'd0);
      check({tag, "_ifu_req"}, 64'(ifu_req_valid_o), 64'd1);
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 1'b0;
      step();
      step();
      check_reset_vals("rst");
      rst_n     = 1'b1;
      m_pc      = RST_PC;
      m_instret = '0;
      m_cycles  = '0;
   endtask

   // A fetch lasts (rdy+1) request cycles plus (rsp+1) wait cycles; ends at the EXEC cycle.
   task automatic do_fetch(input int rdy, input int rsp, input logic [31:0] inst, output int n);
      check("ifu_req_valid", 64'(ifu_req_valid_o), 64'd1);
      for (int i = 0; i < rdy; i++) begin
         ifu_req_ready_i = 1'b0;
         ifu_rsp_valid_i = 1'($urandom);
         ifu_rsp_inst_i  = $urandom;
         scramble();
         step();
      end
      ifu_req_ready_i = 1'b1;
      ifu_rsp_valid_i = 1'($urandom);
      ifu_rsp_inst_i  = $urandom;
      scramble();
      step();
      ifu_req_ready_i = 1'b0;
      for (int i = 0; i < rsp; i++) begin
         ifu_rsp_valid_i = 1'b0;
         scramble();
         step();
      end
      ifu_rsp_valid_i = 1'b1;
      ifu_rsp_inst_i  = inst;
      scramble();
      step();
      ifu_rsp_valid_i = 1'b0;
      ifu_rsp_inst_i  = $urandom;
      check("inst_latched", 64'(inst_o), 64'(inst));
      check("no_wr_in_exec", 64'(rf_wr_en_o), 64'd0);
      n = rdy + rsp + 2;
   endtask

   task automatic do_mem(input int rdy, input int rsp, output int n);
      check("lsu_req_valid", 64'(lsu_req_valid_o), 64'd1);
      for (int i = 0; i < rdy; i++) begin
         lsu_req_ready_i = 1'b0;
         lsu_rsp_valid_i = 1'($urandom);
         scramble();
         step();
      end
      lsu_req_ready_i = 1'b1;
      lsu_rsp_valid_i = 1'($urandom);
      scramble();
      step();
      lsu_req_ready_i = 1'b0;
      check("lsu_req_dropped", 64'(lsu_req_valid_o), 64'd0);
      for (int i = 0; i < rsp; i++) begin
         lsu_rsp_valid_i = 1'b0;
         lsu_req_ready_i = 1'($urandom);
         scramble();
         step();
      end
      lsu_rsp_valid_i = 1'b1;
      scramble();
      step();
      lsu_rsp_valid_i = 1'b0;
      lsu_req_ready_i = 1'b0;
      n = rdy + rsp + 2;
   endtask

   task automatic drive_exec(input logic inv, input logic ebr, input logic ld, input logic st,
                             input logic wr, input logic [63:0] npc);
      invalid_inst_i = inv;
      ebreak_i       = ebr;
      is_load_i      = ld;
      is_store_i     = st;
      rd_wr_en_i     = wr;
      next_pc_i      = npc;
      step();
      scramble();
   endtask

   // kind: 0 ALU/branch, 1 load, 2 store
   task automatic run_inst(input int kind, input int frdy, input int frsp, input int mrdy,
                           input int mrsp, input logic wr, input logic [31:0] inst,
                           input logic [63:0] tgt);
      int n;
      int nm;
      do_fetch(frdy, frsp, inst, n);
      drive_exec(1'b0, 1'b0, kind == 1, kind == 2, wr, tgt);
      n += 1;
      if (kind != 0) begin
         do_mem(mrdy, mrsp, nm);
         n += nm;
      end
      check("wb_wr_en", 64'(rf_wr_en_o), 64'(wr));
      check("wb_sel_mem", 64'(wb_sel_mem_o), 64'(kind == 1));
      step();
      n += 1;
      m_pc      = tgt;
      m_instret = m_instret + 64'd1;
      m_cycles  = m_cycles + 64'(n);
      if (wr) wr_exp++;
      check("pc_after_wb", pc_o, m_pc);
      check("instret", instret_o, m_instret);
      check("cycle", cycle_o, m_cycles);
      check("wr_strobe_one_cycle", 64'(rf_wr_en_o), 64'd0);
   endtask

   initial begin
      int n;
      logic [63:0] hold;

      idle();
      apply_reset();

      // Zero-wait addi: write strobe in cycle 4.
      run_inst(0, 0, 0, 0, 0, 1'b1, 32'h0010_0093, 64'h8000_0004);
      check("addi_cycles", cycle_o, 64'd4);
      // Load with ready delayed 3 cycles: 9 cycles.
      run_inst(1, 0, 0, 3, 0, 1'b1, 32'h0000_3083, 64'h8000_0008);
      check("load_cycles", cycle_o, 64'd13);
      // Store without register write: 6 cycles, no strobe.
      run_inst(2, 0, 0, 0, 0, 1'b0, 32'h0010_3023, 64'h8000_000c);
      check("store_cycles", cycle_o, 64'd19);
      // Every handshake lands exactly as the wait count reaches the limit.
      run_inst(1, TMO, TMO, TMO, TMO, 1'b1, 32'h0000_3103, 64'h8000_0010);

      for (int i = 0; i < 40; i++) begin
         run_inst(int'($urandom_range(0, 2)), int'($urandom_range(0, TMO)),
                  int'($urandom_range(0, TMO)), int'($urandom_range(0, TMO)),
                  int'($urandom_range(0, TMO)), 1'($urandom), $urandom,
                  {$urandom, $urandom} & ~64'h3);
      end

      // ebreak halts, outranks a misaligned target, and freezes everything.
      do_fetch(2, 1, 32'h0010_0073, n);
      drive_exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h3);
      hold = m_cycles + 64'(n) + 64'd1;
      check("halt_set", 64'(halt_o), 64'd1);
      check("halt_no_trap", 64'(trap_o), 64'd0);
      for (int i = 0; i < 20; i++) begin
         ifu_req_ready_i = 1'b1;
         ifu_rsp_valid_i = 1'b1;
         lsu_req_ready_i = 1'b1;
         lsu_rsp_valid_i = 1'b1;
         check("halt_no_fetch", 64'(ifu_req_valid_o), 64'd0);
         step();
      end
      check("halt_instret", instret_o, m_instret);
      check("halt_cycle_frozen", cycle_o, hold);
      check("halt_pc", pc_o, m_pc);
      check("halt_no_lsu", 64'(lsu_req_valid_o), 64'd0);

      // Invalid instruction outranks ebreak.
      apply_reset();
      do_fetch(0, 0, 32'hffff_ffff, n);
      drive_exec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0004);
      check("inv_trap", 64'({trap_o, trap_cause_o}), 64'b101);
      check("inv_no_halt", 64'(halt_o), 64'd0);
      step();
      check("inv_no_fetch", 64'(ifu_req_valid_o), 64'd0);

      // Misaligned next PC.
      apply_reset();
      do_fetch(1, 0, 32'h0000_006f, n);
      drive_exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0006);
      check("mis_trap", 64'({trap_o, trap_cause_o}), 64'b111);
      check("mis_no_lsu", 64'(lsu_req_valid_o), 64'd0);
      check("mis_instret", instret_o, 64'd0);

      // Fetch response never arrives: 9 wait cycles (counts 0..TMO) and then trap.
      apply_reset();
      ifu_req_ready_i = 1'b1;
      step();
      ifu_req_ready_i = 1'b0;
      for (int k = 0; k <= TMO; k++) begin
         check("tmo_not_early", 64'(trap_o), 64'd0);
         step();
      end
      check("tmo_trap", 64'({trap_o, trap_cause_o}), 64'b110);
      check("tmo_cycle", cycle_o, 64'(TMO + 2));
      check("tmo_no_fetch", 64'(ifu_req_valid_o), 64'd0);

      // Load response never arrives.
      apply_reset();
      do_fetch(0, 0, 32'h0000_3083, n);
      drive_exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0004);
      lsu_req_ready_i = 1'b1;
      step();
      lsu_req_ready_i = 1'b0;
      for (int k = 0; k <= TMO; k++) begin
         lsu_rsp_valid_i = 1'b0;
         step();
      end
      check("lsu_tmo_trap", 64'({trap_o, trap_cause_o}), 64'b110);
      check("lsu_tmo_no_wr", 64'(rf_wr_en_o), 64'd0);

      // Asynchronous reset in MEM_WAIT drops the outstanding response.
      apply_reset();
      do_fetch(0, 0, 32'h0000_3083, n);
      drive_exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0040);
      lsu_req_ready_i = 1'b1;
      step();
      lsu_req_ready_i = 1'b0;
      #3;
      rst_n = 1'b0;
      lsu_rsp_valid_i = 1'b1;
      #1;
      check_reset_vals("async");
      step();
      step();
      idle();
      rst_n     = 1'b1;
      m_pc      = RST_PC;
      m_instret = '0;
      m_cycles  = '0;
      check_reset_vals("post_rst");
      run_inst(0, 0, 0, 0, 0, 1'b1, 32'h0010_0093, 64'h8000_0004);

      check("wr_pulse_total", 64'(wr_seen), 64'(wr_exp));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
